apb_capture_regs: RTL and testbench
===================================

Name: apb_capture_regs

Overview:
- APB3 completer (responder) register bank for the ADC capture engine. It is the target end of the CPU's APB initiator port.
- Decodes CPU read/write transfers with programmable wait states and drives capture configuration plus a start pulse.
- Collects busy/done status from the capture engine and raises a level interrupt to the CPU subsystem.

Parameters:
- ADDR_W, 8, number of paddr bits decoded; upper initiator address bits are stripped by the interconnect.
- WAIT_STATES, 0, extra ACCESS cycles before pready (0..3).
- ID_VALUE, 32'h4144_4301, constant returned by the ID register.

Ports:
- hfclk_i  in  1  system clock; all logic is on the rising edge.
- erst_i  in  1  asynchronous active-high reset.
- paddr  in  ADDR_W  APB address (byte address; bits[1:0] ignored).
- psel  in  1  APB select.
- penable  in  1  APB enable (ACCESS phase).
- pwrite  in  1  1=write, 0=read.
- pwdata  in  32  write data.
- pready  out  1  transfer completes this cycle.
- prdata  out  32  read data; valid only when pready=1.
- pslverr  out  1  error response; valid only when pready=1.
- cap_start_o  out  1  one-cycle start pulse to the capture engine.
- cap_len_o  out  16  capture length in samples.
- cap_cfg_o  out  8  capture mode/config bits.
- cap_busy_i  in  1  capture in progress.
- cap_done_i  in  1  one-cycle completion pulse.
- cap_wr_cnt_i  in  16  samples written so far.
- irq_o  out  1  level interrupt = DONE & IRQ_EN.

Behaviour:
- Reset (erst_i=1, asynchronous): all registers 0; pready=0, prdata=0, pslverr=0, cap_start_o=0, irq_o=0; wait counter=0. A transfer in flight is dropped with no write side effect.
- Register map (offset, access):
  - 0x00 CTRL: bit0 START write-1-to-pulse, reads 0; bit1 IRQ_EN RW.
  - 0x04 LEN: RW [15:0].
  - 0x08 CFG: RW [7:0].
  - 0x0C STATUS: bit0 BUSY RO (live cap_busy_i); bit1 DONE sticky W1C; bit2 START_REJ sticky W1C; [31:16] WR_CNT RO.
  - 0x10 SCRATCH: RW [31:0].
  - 0x14 ID: RO = ID_VALUE.
- Unused register bits read 0 and ignore writes.
- Wait-state counter wcnt (2 bits):
  - Clears whenever !(psel & penable).
  - Increments each cycle psel & penable & wcnt != WAIT_STATES.
  - pready = psel & penable & (wcnt == WAIT_STATES), combinational from wcnt.
  - With WAIT_STATES=0, pready is high in the first ACCESS cycle. Total latency is SETUP + ACCESS + WAIT_STATES cycles.
- Commit: a write updates registers on the clock edge where pready=1 & pwrite. Nothing changes before that edge.
- Aborted transfer (psel dropped before pready): no side effects; wcnt clears.
- prdata: mux of the addressed register when pready & !pwrite, else 0.
- pslverr=1 with pready on:
  - any access to an unmapped offset (≥0x18);
  - a write to ID.
  - Register state is unchanged in both cases.
- A write to STATUS is legal. Only bits 1 and 2 are affected, both W1C.
- START:
  - Write with bit0=1 while cap_busy_i=0: cap_start_o=1 on the next cycle for exactly one cycle.
  - Write with bit0=1 while cap_busy_i=1: no pulse; START_REJ set. pslverr stays 0.
- DONE set by cap_done_i. If cap_done_i and a W1C of DONE occur in the same cycle, set wins (DONE=1).
- irq_o registered: follows DONE & IRQ_EN one cycle later.
- cap_len_o and cap_cfg_o are direct register outputs. Software must not change them while BUSY; hardware does not block such writes.
- Back-to-back transfers (ACCESS followed directly by SETUP) are supported with no idle cycle required.

Decomposition:
- Package cap_regs_pkg:
  - register offsets (CTRL/LEN/CFG/STATUS/SCRATCH/ID);
  - field bit positions (START, IRQ_EN, BUSY, DONE, START_REJ, WR_CNT LSB);
  - last-valid-offset constant;
  - default ID_VALUE.
- Sub-module apb_wait_ctr (wcnt + pready generation), reusable by other APB completers. The register bank stays in the top module.

Test Plan:
- Reset, WAIT_STATES=0: read ID at 0x14 → prdata=32'h41444301, pready in the first ACCESS cycle, pslverr=0. Read CTRL, LEN, CFG, SCRATCH, STATUS (with cap_busy_i=0, cap_wr_cnt_i=0) → all 0.
- WAIT_STATES=2: write SCRATCH=32'hDEADBEEF → pready asserted 3rd ACCESS cycle. Readback = DEADBEEF. Abort a write to SCRATCH after 1 ACCESS cycle → value unchanged.
- Write CTRL=0x3 with busy=0 → cap_start_o single pulse one cycle after commit, IRQ_EN=1. Repeat with busy=1 → no pulse, STATUS bit2=1.
- Pulse cap_done_i → STATUS bit1=1 and irq_o=1 next cycle. W1C 0x2 to STATUS in the same cycle as a new cap_done_i → DONE stays 1. Later W1C alone → DONE=0, irq_o=0.
- Write 0x18 and write 0x14 → pslverr=1, no state change. Read 0x20 → pslverr=1, prdata=0.
- Assert erst_i mid-ACCESS of a LEN write of 0x1234 → LEN=0, pready=0, no commit after release.

Source files
------------

// File: rtl/cap_regs_pkg.sv
// Register map, field positions and address decode shared by the ADC capture
// register bank.
package cap_regs_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_LEN     = 32'h04;
    localparam logic [31:0] OFF_CFG     = 32'h08;
    localparam logic [31:0] OFF_STATUS  = 32'h0C;
    localparam logic [31:0] OFF_SCRATCH = 32'h10;
    localparam logic [31:0] OFF_ID      = 32'h14;
    localparam logic [31:0] OFF_LAST    = OFF_ID;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;
    localparam int STAT_REJ_BIT    = 2;
    localparam int STAT_WRCNT_LSB  = 16;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4144_4301;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_LEN,
        REG_CFG,
        REG_STATUS,
        REG_SCRATCH,
        REG_ID,
        REG_NONE
    } reg_sel_e;

    // Byte-lane bits are ignored; anything past the ID register is unmapped.
    function automatic reg_sel_e decode(input logic [31:0] addr);
        logic [31:0] w_word;
        w_word = addr & 32'hFFFF_FFFC;
        case (w_word)
            OFF_CTRL:    decode = REG_CTRL;
            OFF_LEN:     decode = REG_LEN;
            OFF_CFG:     decode = REG_CFG;
            OFF_STATUS:  decode = REG_STATUS;
            OFF_SCRATCH: decode = REG_SCRATCH;
            OFF_ID:      decode = REG_ID;
            default:     decode = REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// APB completer wait-state counter: holds pready low for WAIT_STATES extra
// ACCESS cycles, then completes the transfer.
module apb_wait_ctr #(
    parameter int WAIT_STATES = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready
);

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    logic [1:0] r_wcnt;
    logic       w_access;

    assign w_access = i_psel & i_penable;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wcnt <= '0;
        end else if (!w_access) begin
            r_wcnt <= '0;
        end else if (r_wcnt != WS) begin
            r_wcnt <= r_wcnt + 2'd1;
        end
    end

    // Gated by reset so a zero-wait completer cannot complete while held in reset.
    assign o_pready = !i_rst & w_access & (r_wcnt == WS);

endmodule

// File: rtl/apb_capture_regs.sv
// APB3 register bank for the ADC capture engine: configuration, start pulse,
// sticky status and level interrupt.
module apb_capture_regs
    import cap_regs_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic              hfclk_i,
    input  logic              erst_i,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              cap_start_o,
    output logic [15:0]       cap_len_o,
    output logic [7:0]        cap_cfg_o,
    input  logic              cap_busy_i,
    input  logic              cap_done_i,
    input  logic [15:0]       cap_wr_cnt_i,
    output logic              irq_o
);

    logic        w_pready;
    reg_sel_e    w_sel;
    logic        w_err;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_start_req;
    logic [31:0] w_rdata;

    logic        r_irq_en;
    logic [15:0] r_len;
    logic [7:0]  r_cfg;
    logic [31:0] r_scratch;
    logic        r_done;
    logic        r_rej;
    logic        r_start;
    logic        r_irq;

    apb_wait_ctr #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_ctr (
        .i_clk    (hfclk_i),
        .i_rst    (erst_i),
        .i_psel   (psel),
        .i_penable(penable),
        .o_pready (w_pready)
    );

    assign w_sel       = decode(32'(paddr));
    assign w_err       = (w_sel == REG_NONE) | (pwrite & (w_sel == REG_ID));
    assign w_wr        = w_pready & pwrite & !w_err;
    assign w_wr_ctrl   = w_wr & (w_sel == REG_CTRL);
    assign w_wr_status = w_wr & (w_sel == REG_STATUS);
    assign w_start_req = w_wr_ctrl & pwdata[CTRL_START_BIT];

    always_ff @(posedge hfclk_i or posedge erst_i) begin
        if (erst_i) begin
            r_irq_en  <= 1'b0;
            r_len     <= '0;
            r_cfg     <= '0;
            r_scratch <= '0;
            r_done    <= 1'b0;
            r_rej     <= 1'b0;
            r_start   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= pwdata[CTRL_IRQ_EN_BIT];
            end
            if (w_wr && (w_sel == REG_LEN)) begin
                r_len <= pwdata[15:0];
            end
            if (w_wr && (w_sel == REG_CFG)) begin
                r_cfg <= pwdata[7:0];
            end
            if (w_wr && (w_sel == REG_SCRATCH)) begin
                r_scratch <= pwdata;
            end
            r_start <= w_start_req & !cap_busy_i;
            r_rej   <= (w_start_req & cap_busy_i)
                     | (r_rej & !(w_wr_status & pwdata[STAT_REJ_BIT]));
            // A completion arriving with a W1C of DONE must not be lost.
            r_done  <= cap_done_i
                     | (r_done & !(w_wr_status & pwdata[STAT_DONE_BIT]));
            r_irq   <= r_done & r_irq_en;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_CTRL:    w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            REG_LEN:     w_rdata[15:0] = r_len;
            REG_CFG:     w_rdata[7:0] = r_cfg;
            REG_STATUS: begin
                w_rdata[STAT_BUSY_BIT]          = cap_busy_i;
                w_rdata[STAT_DONE_BIT]          = r_done;
                w_rdata[STAT_REJ_BIT]           = r_rej;
                w_rdata[STAT_WRCNT_LSB +: 16]   = cap_wr_cnt_i;
            end
            REG_SCRATCH: w_rdata = r_scratch;
            REG_ID:      w_rdata = ID_VALUE;
            default:     w_rdata = '0;
        endcase
    end

    assign pready      = w_pready;
    assign prdata      = (w_pready & !pwrite) ? w_rdata : '0;
    assign pslverr     = w_pready & w_err;
    assign cap_start_o = r_start;
    assign cap_len_o   = r_len;
    assign cap_cfg_o   = r_cfg;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_apb_capture_regs.sv
// Bench for apb_capture_regs: a zero-wait and a two-wait instance, each tracked
// by a register-level model checked every cycle, plus directed literal checks.
module tb_apb_capture_regs;

    localparam logic [31:0] ID_EXP = 32'h4144_4301;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0][7:0]  paddr   = '0;
    logic [1:0]       psel    = '0;
    logic [1:0]       penable = '0;
    logic [1:0]       pwrite  = '0;
    logic [1:0][31:0] pwdata  = '0;
    logic [1:0]       pready;
    logic [1:0][31:0] prdata;
    logic [1:0]       pslverr;
    logic [1:0]       cap_start;
    logic [1:0][15:0] cap_len;
    logic [1:0][7:0]  cap_cfg;
    logic [1:0]       irq;

    logic        busy  = 1'b0;
    logic        done  = 1'b0;
    logic [15:0] wrcnt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_capture_regs #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .hfclk_i(clk), .erst_i(rst),
        .paddr(paddr[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
        .cap_start_o(cap_start[0]), .cap_len_o(cap_len[0]), .cap_cfg_o(cap_cfg[0]),
        .cap_busy_i(busy), .cap_done_i(done), .cap_wr_cnt_i(wrcnt), .irq_o(irq[0])
    );

    apb_capture_regs #(.ADDR_W(8), .WAIT_STATES(2)) u_dut1 (
        .hfclk_i(clk), .erst_i(rst),
        .paddr(paddr[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
        .cap_start_o(cap_start[1]), .cap_len_o(cap_len[1]), .cap_cfg_o(cap_cfg[1]),
        .cap_busy_i(busy), .cap_done_i(done), .cap_wr_cnt_i(wrcnt), .irq_o(irq[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- register-level model ----------------
    logic [15:0] m_len   [2] = '{16'h0, 16'h0};
    logic [7:0]  m_cfg   [2] = '{8'h0, 8'h0};
    logic [31:0] m_scr   [2] = '{32'h0, 32'h0};
    logic        m_irqen [2] = '{1'b0, 1'b0};
    logic        m_done  [2] = '{1'b0, 1'b0};
    logic        m_rej   [2] = '{1'b0, 1'b0};
    logic        m_start [2] = '{1'b0, 1'b0};
    logic        m_irq   [2] = '{1'b0, 1'b0};
    int          m_acc   [2] = '{0, 0};

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic [7:0] word(input int d);
        return paddr[d] & 8'hFC;
    endfunction

    function automatic logic rdy_of(input int d);
        return !rst && psel[d] && penable[d] && (m_acc[d] == ws_of(d));
    endfunction

    function automatic logic wr_of(input int d);
        return rdy_of(d) && pwrite[d] && (word(d) <= 8'h10);
    endfunction

    // {error, data} for a read of the currently addressed register.
    function automatic logic [32:0] model_read(input int d);
        case (word(d))
            8'h00:   return {1'b0, 30'h0, m_irqen[d], 1'b0};
            8'h04:   return {1'b0, 16'h0, m_len[d]};
            8'h08:   return {1'b0, 24'h0, m_cfg[d]};
            8'h0C:   return {1'b0, wrcnt, 13'h0, m_rej[d], m_done[d], busy};
            8'h10:   return {1'b0, m_scr[d]};
            8'h14:   return {1'b0, ID_EXP};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_len[d] <= '0; m_cfg[d] <= '0; m_scr[d] <= '0; m_irqen[d] <= 1'b0;
                m_done[d] <= 1'b0; m_rej[d] <= 1'b0; m_start[d] <= 1'b0;
                m_irq[d] <= 1'b0; m_acc[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wr_of(d) && word(d) == 8'h00) m_irqen[d] <= pwdata[d][1];
                if (wr_of(d) && word(d) == 8'h04) m_len[d] <= pwdata[d][15:0];
                if (wr_of(d) && word(d) == 8'h08) m_cfg[d] <= pwdata[d][7:0];
                if (wr_of(d) && word(d) == 8'h10) m_scr[d] <= pwdata[d];
                m_start[d] <= wr_of(d) && word(d) == 8'h00 && pwdata[d][0] && !busy;
                m_rej[d]   <= (wr_of(d) && word(d) == 8'h00 && pwdata[d][0] && busy)
                           || (m_rej[d] && !(wr_of(d) && word(d) == 8'h0C && pwdata[d][2]));
                m_done[d]  <= done
                           || (m_done[d] && !(wr_of(d) && word(d) == 8'h0C && pwdata[d][1]));
                m_irq[d]   <= m_done[d] && m_irqen[d];
                if (!(psel[d] && penable[d])) m_acc[d] <= 0;
                else if (!rdy_of(d))          m_acc[d] <= m_acc[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        e_rdy;
            logic [32:0] e_rd;
            e_rdy = rdy_of(d);
            e_rd  = model_read(d);
            check($sformatf("d%0d_pready", d), 32'(pready[d]), 32'(e_rdy));
            check($sformatf("d%0d_prdata", d), prdata[d],
                  (e_rdy && !pwrite[d]) ? e_rd[31:0] : 32'h0);
            check($sformatf("d%0d_pslverr", d), 32'(pslverr[d]),
                  32'(e_rdy && (e_rd[32] || (pwrite[d] && word(d) == 8'h14))));
            check($sformatf("d%0d_start", d), 32'(cap_start[d]), 32'(m_start[d]));
            check($sformatf("d%0d_len", d), 32'(cap_len[d]), 32'(m_len[d]));
            check($sformatf("d%0d_cfg", d), 32'(cap_cfg[d]), 32'(m_cfg[d]));
            check($sformatf("d%0d_irq", d), 32'(irq[d]), 32'(m_irq[d]));
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1; returns at posedge+1 after the completing edge so
    // consecutive calls are back-to-back.
    task automatic apb(input int d, input logic [7:0] a, input logic w, input logic [31:0] wd,
                       input logic done_on_access,
                       output logic [31:0] rd, output logic err, output int cycles);
        rd = '0; err = 1'b0; cycles = 0;
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = w; pwdata[d] = wd;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        if (done_on_access) done = 1'b1;
        forever begin
            @(negedge clk);
            cycles++;
            if (pready[d]) begin
                rd = prdata[d]; err = pslverr[d];
                break;
            end
            if (cycles >= 16) begin
                n_tests++; n_fail++;
                $display("FAIL d%0d_timeout: no pready after %0d cycles, expected %0d",
                         d, cycles, ws_of(d) + 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (done_on_access) done = 1'b0;
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [31:0] v);
        logic [31:0] rd; logic err; int cyc;
        apb(d, a, 1'b1, v, 1'b0, rd, err, cyc);
        check($sformatf("d%0d_wr_%h_err", d, a), 32'(err), 32'h0);
    endtask

    task automatic rd_chk(input int d, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic err; int cyc;
        apb(d, a, 1'b0, 32'h0, 1'b0, rd, err, cyc);
        check($sformatf("d%0d_rd_%h", d, a), rd, exp);
        check($sformatf("d%0d_rd_%h_err", d, a), 32'(err), 32'h0);
    endtask

    initial begin
        logic [31:0] rd; logic err; int cyc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_reset_pready", d), 32'(pready[d]), 32'h0);
            check($sformatf("d%0d_reset_start", d), 32'(cap_start[d]), 32'h0);
            check($sformatf("d%0d_reset_irq", d), 32'(irq[d]), 32'h0);
            check($sformatf("d%0d_reset_len", d), 32'(cap_len[d]), 32'h0);
        end

        // zero-wait instance: ID and reset values
        apb(0, 8'h14, 1'b0, 32'h0, 1'b0, rd, err, cyc);
        check("d0_id", rd, 32'h4144_4301);
        check("d0_id_err", 32'(err), 32'h0);
        check("d0_id_latency", 32'(cyc), 32'd1);
        rd_chk(0, 8'h00, 32'h0);
        rd_chk(0, 8'h04, 32'h0);
        rd_chk(0, 8'h08, 32'h0);
        rd_chk(0, 8'h10, 32'h0);
        rd_chk(0, 8'h0C, 32'h0);

        // two-wait instance: latency, readback, aborted write
        apb(1, 8'h10, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, err, cyc);
        check("d1_scratch_latency", 32'(cyc), 32'd3);
        rd_chk(1, 8'h10, 32'hDEAD_BEEF);
        psel[1] = 1'b1; paddr[1] = 8'h10; pwrite[1] = 1'b1; pwdata[1] = 32'h1234_5678;
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
        rd_chk(1, 8'h10, 32'hDEAD_BEEF);
        rd_chk(1, 8'h13, 32'hDEAD_BEEF);

        // back-to-back writes/reads, unused bits ignored
        wr(0, 8'h04, 32'hFFFF_BEEF);
        rd_chk(0, 8'h04, 32'h0000_BEEF);
        wr(0, 8'h08, 32'h0000_01A5);
        rd_chk(0, 8'h08, 32'h0000_00A5);
        check("d0_len_out", 32'(cap_len[0]), 32'h0000_BEEF);

        // start accepted, then rejected while busy
        wr(0, 8'h00, 32'h3);
        check("d0_start_pulse", 32'(cap_start[0]), 32'h1);
        @(posedge clk); #1;
        check("d0_start_once", 32'(cap_start[0]), 32'h0);
        rd_chk(0, 8'h00, 32'h2);
        busy = 1'b1; wrcnt = 16'h0042;
        wr(0, 8'h00, 32'h3);
        check("d0_start_rej_nopulse", 32'(cap_start[0]), 32'h0);
        rd_chk(0, 8'h0C, 32'h0042_0005);
        busy = 1'b0;
        wr(0, 8'h0C, 32'h4);
        rd_chk(0, 8'h0C, 32'h0042_0000);

        // done pulse, interrupt, W1C collision, W1C alone
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        @(posedge clk); #1;
        check("d0_irq_set", 32'(irq[0]), 32'h1);
        rd_chk(0, 8'h0C, 32'h0042_0002);
        apb(0, 8'h0C, 1'b1, 32'h2, 1'b1, rd, err, cyc);
        rd_chk(0, 8'h0C, 32'h0042_0002);
        check("d0_irq_kept", 32'(irq[0]), 32'h1);
        wr(0, 8'h0C, 32'h2);
        rd_chk(0, 8'h0C, 32'h0042_0000);
        check("d0_irq_clr", 32'(irq[0]), 32'h0);

        // error responses leave state untouched
        apb(0, 8'h18, 1'b1, 32'hCAFE_F00D, 1'b0, rd, err, cyc);
        check("d0_wr18_err", 32'(err), 32'h1);
        apb(0, 8'h14, 1'b1, 32'hCAFE_F00D, 1'b0, rd, err, cyc);
        check("d0_wrid_err", 32'(err), 32'h1);
        apb(0, 8'h20, 1'b0, 32'h0, 1'b0, rd, err, cyc);
        check("d0_rd20_err", 32'(err), 32'h1);
        check("d0_rd20_data", rd, 32'h0);
        rd_chk(0, 8'h14, 32'h4144_4301);
        rd_chk(0, 8'h10, 32'h0);
        rd_chk(0, 8'h04, 32'h0000_BEEF);

        // reset in the middle of a wait-stated LEN write
        wr(1, 8'h04, 32'h5555);
        psel[1] = 1'b1; paddr[1] = 8'h04; pwrite[1] = 1'b1; pwdata[1] = 32'h1234;
        @(posedge clk); #1 penable[1] = 1'b1;
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("d1_rst_pready", 32'(pready[1]), 32'h0);
        check("d1_rst_len", 32'(cap_len[1]), 32'h0);
        @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("d1_after_rst_len", 32'(cap_len[1]), 32'h0);
        rd_chk(1, 8'h04, 32'h0);
        rd_chk(0, 8'h04, 32'h0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
